// File: rtl/fifo_burst_param.sv
// fifo_burst_param: parametrised synchronous FIFO with occupancy count,
// sticky overflow/underflow flags and a burst-read FSM that pops
// burst_len words on consecutive cycles from a single request strobe.
// All command inputs are expected to be 1-cycle strobes.
module fifo_burst_param #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic              read_more,
  input  logic [AW:0]       burst_len,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [AW:0]       count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_threshold,
  output logic              overflow,
  output logic              underflow,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   THR_CNT  = (AW+1)'(THRESH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     rptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       rem_r;
  state_t            state_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              overflow_r;
  logic              underflow_r;

  logic pop_req_s;
  logic pop_ok_s;
  logic pop_err_s;
  logic wr_ok_s;
  logic wr_err_s;
  logic empty_s;
  logic full_s;

  assign empty_s = (count_r == CNT_ZERO);
  assign full_s  = (count_r == FULL_CNT);

  // Pop/write qualification; a same-cycle pop frees a slot for a write into a full FIFO.
  always_comb begin
    pop_req_s = 1'b0;
    case (state_r)
      IDLE:    pop_req_s = rd && !read_more;
      BURST:   pop_req_s = 1'b1;
      default: pop_req_s = 1'b0;
    endcase
    pop_ok_s  = pop_req_s && !empty_s;
    pop_err_s = pop_req_s && empty_s;
    wr_ok_s   = wr && (!full_s || pop_ok_s);
    wr_err_s  = wr && !wr_ok_s;
  end

  // Storage array; not reset, written only when a write is accepted.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_s) begin
      mem_r[wptr_r] <= data_in;
    end
  end

  // Pointers, occupancy, pop data, sticky errors and burst FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r       <= PTR_ZERO;
      rptr_r       <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      rem_r        <= CNT_ZERO;
      state_r      <= IDLE;
      data_out_r   <= {DATA_W{1'b0}};
      data_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rptr_r     <= rptr_r + PTR_ONE;
        data_out_r <= mem_r[rptr_r];
      end
      data_valid_r <= pop_ok_s;

      case ({wr_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase

      // A new error in the same cycle as clr_err keeps the flag set.
      if (wr_err_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (pop_err_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (read_more && (burst_len != CNT_ZERO)) begin
            rem_r   <= burst_len;
            state_r <= BURST;
          end
        end
        BURST: begin
          if (empty_s) begin
            rem_r   <= CNT_ZERO;
            state_r <= IDLE;
          end else if (rem_r == CNT_ONE) begin
            rem_r   <= CNT_ZERO;
            state_r <= IDLE;
          end else begin
            rem_r <= rem_r - CNT_ONE;
          end
        end
        default: begin
          rem_r   <= CNT_ZERO;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign data_out       = data_out_r;
  assign data_valid     = data_valid_r;
  assign count          = count_r;
  assign fifo_full      = full_s;
  assign fifo_empty     = empty_s;
  assign fifo_threshold = (count_r >= THR_CNT);
  assign overflow       = overflow_r;
  assign underflow      = underflow_r;
  assign busy           = (state_r == BURST);

endmodule

// File: tb/tb_fifo_burst_param.sv
// Directed testbench for fifo_burst_param (DATA_W=4, DEPTH=16, THRESH=8).
module tb_fifo_burst_param;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic       read_more;
  logic [4:0] burst_len;
  logic       clr_err;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       data_valid;
  logic [4:0] count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_threshold;
  logic       overflow;
  logic       underflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  fifo_burst_param #(.DATA_W(4), .DEPTH(16), .THRESH(8)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .read_more(read_more),
    .burst_len(burst_len), .clr_err(clr_err), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .count(count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_threshold(fifo_threshold), .overflow(overflow),
    .underflow(underflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] d);
    wr = 1'b1; data_in = d; step(); wr = 1'b0;
  endtask

  task automatic pop1();
    rd = 1'b1; step(); rd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifo_full); end
    checks++; if (fifo_threshold !== 1'b0) begin errors++; $display("FAIL reset_thresh got %b exp 0", fifo_threshold); end
    checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_out); end
    checks++; if ({overflow, underflow, busy, data_valid} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {overflow, underflow, busy, data_valid}); end
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(4'(i));
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      checks++; if (fifo_threshold !== ((i + 1) >= 8)) begin errors++; $display("FAIL fill_thresh[%0d] got %b exp %b", i, fifo_threshold, ((i + 1) >= 8)); end
    end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", fifo_full); end
    push(4'hF);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_ovf_count got %0d exp 16", count); end
    for (int i = 0; i < 16; i++) begin
      pop1();
      checks++; if (data_out !== 4'(i) || data_valid !== 1'b1) begin errors++; $display("FAIL drain_data[%0d] got %h/%b exp %h/1", i, data_out, data_valid, 4'(i)); end
    end
    checks++; if (fifo_empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL drain_empty got %b/%0d exp 1/0", fifo_empty, count); end
    step();
    checks++; if (data_valid !== 1'b0 || data_out !== 4'hF) begin errors++; $display("FAIL hold_data got %b/%h exp 0/f", data_valid, data_out); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b exp 0", overflow); end
    push(4'h7); push(4'h8); push(4'h9);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", count); end
    pop1();
    checks++; if (data_out !== 4'h7) begin errors++; $display("FAIL wrap_data0 got %h exp 7", data_out); end
    pop1();
    checks++; if (data_out !== 4'h8) begin errors++; $display("FAIL wrap_data1 got %h exp 8", data_out); end
    pop1();
    checks++; if (data_out !== 4'h9) begin errors++; $display("FAIL wrap_data2 got %h exp 9", data_out); end
  endtask

  task automatic test_burst();
    logic [3:0] exp_d [3];
    exp_d[0] = 4'hA; exp_d[1] = 4'hB; exp_d[2] = 4'hC;
    do_reset();
    push(4'hA); push(4'hB); push(4'hC); push(4'hD); push(4'hE);
    read_more = 1'b1; burst_len = 5'd3; step(); read_more = 1'b0;
    checks++; if (busy !== 1'b1 || data_valid !== 1'b0) begin errors++; $display("FAIL burst_start got busy=%b dv=%b exp 1/0", busy, data_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (data_valid !== 1'b1 || data_out !== exp_d[i]) begin errors++; $display("FAIL burst_data[%0d] got %b/%h exp 1/%h", i, data_valid, data_out, exp_d[i]); end
    end
    checks++; if (busy !== 1'b0 || count !== 5'd2 || underflow !== 1'b0) begin errors++; $display("FAIL burst_end got busy=%b cnt=%0d uf=%b exp 0/2/0", busy, count, underflow); end
    step();
    checks++; if (data_valid !== 1'b0 || count !== 5'd2) begin errors++; $display("FAIL burst_after got dv=%b cnt=%0d exp 0/2", data_valid, count); end
  endtask

  task automatic test_burst_early();
    do_reset();
    push(4'h1); push(4'h2);
    read_more = 1'b1; burst_len = 5'd5; step(); read_more = 1'b0;
    step();
    checks++; if (data_out !== 4'h1 || data_valid !== 1'b1) begin errors++; $display("FAIL early_d0 got %h/%b exp 1/1", data_out, data_valid); end
    step();
    checks++; if (data_out !== 4'h2 || busy !== 1'b1) begin errors++; $display("FAIL early_d1 got %h busy=%b exp 2/1", data_out, busy); end
    step();
    checks++; if (underflow !== 1'b1 || busy !== 1'b0 || fifo_empty !== 1'b1 || data_valid !== 1'b0) begin errors++; $display("FAIL early_stop got uf=%b busy=%b empty=%b dv=%b exp 1/0/1/0", underflow, busy, fifo_empty, data_valid); end
    rd = 1'b1; clr_err = 1'b1; step(); rd = 1'b0; clr_err = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clr_vs_new got %b exp 1", underflow); end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_underflow got %b exp 0", underflow); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 16; i++) push(4'(i + 2));
    wr = 1'b1; rd = 1'b1; data_in = 4'h9; step(); wr = 1'b0; rd = 1'b0;
    checks++; if (count !== 5'd16 || overflow !== 1'b0) begin errors++; $display("FAIL sim_full got cnt=%0d ovf=%b exp 16/0", count, overflow); end
    checks++; if (data_out !== 4'h2 || data_valid !== 1'b1) begin errors++; $display("FAIL sim_full_data got %h/%b exp 2/1", data_out, data_valid); end
    do_reset();
    wr = 1'b1; rd = 1'b1; data_in = 4'h5; step(); wr = 1'b0; rd = 1'b0;
    checks++; if (underflow !== 1'b1 || count !== 5'd1 || data_valid !== 1'b0) begin errors++; $display("FAIL sim_empty got uf=%b cnt=%0d dv=%b exp 1/1/0", underflow, count, data_valid); end
    pop1();
    checks++; if (data_out !== 4'h5) begin errors++; $display("FAIL sim_empty_data got %h exp 5", data_out); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push(4'h3); push(4'h4); push(4'h6);
    read_more = 1'b1; burst_len = 5'd3; step(); read_more = 1'b0;
    step();
    checks++; if (busy !== 1'b1 || data_out !== 4'h3) begin errors++; $display("FAIL mid_busy got %b/%h exp 1/3", busy, data_out); end
    do_reset();
    checks++; if (busy !== 1'b0 || count !== 5'd0 || data_out !== 4'h0) begin errors++; $display("FAIL mid_reset got busy=%b cnt=%0d d=%h exp 0/0/0", busy, count, data_out); end
    push(4'hC);
    read_more = 1'b1; burst_len = 5'd0; step(); read_more = 1'b0;
    checks++; if (busy !== 1'b0 || count !== 5'd1 || data_valid !== 1'b0) begin errors++; $display("FAIL len0 got busy=%b cnt=%0d dv=%b exp 0/1/0", busy, count, data_valid); end
    rd = 1'b1; read_more = 1'b1; burst_len = 5'd1; step(); rd = 1'b0; read_more = 1'b0;
    checks++; if (busy !== 1'b1 || count !== 5'd1 || data_valid !== 1'b0) begin errors++; $display("FAIL prio got busy=%b cnt=%0d dv=%b exp 1/1/0", busy, count, data_valid); end
    step();
    checks++; if (busy !== 1'b0 || data_out !== 4'hC || count !== 5'd0 || underflow !== 1'b0) begin errors++; $display("FAIL prio_pop got busy=%b d=%h cnt=%0d uf=%b exp 0/c/0/0", busy, data_out, count, underflow); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; read_more = 1'b0;
    burst_len = 5'd0; clr_err = 1'b0; data_in = 4'h0;
    step();
    test_reset();
    test_fill_wrap();
    test_burst();
    test_burst_early();
    test_simultaneous();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
